// File: rtl/clocks_pkg.sv
// Shared FSM encoding and default constants for the clock-enable monitors.
// Latency: n/a (types/constants only); backpressure: n/a.
package clocks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } mon_state_t;

    localparam logic [15:0] DEF_WINDOW    = 16'd53600;
    localparam logic [15:0] DEF_EXP_COUNT = 16'd13400;
    localparam logic [15:0] DEF_TOL       = 16'd1;
    localparam logic [3:0]  DEF_LOCK_N    = 4'd4;

    function automatic logic [16:0] abs_diff17(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, b} - {1'b0, a};
        return d;
    endfunction

endpackage

// File: rtl/cen_phase_check.sv
// Alternation/coincidence checker for a complementary strobe pair; o_viol is combinational.
// Latency: 0 cycles to o_viol; no backpressure, strobes are sampled every cycle.
module cen_phase_check
    import clocks_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_cen,
    input  logic i_cenb,
    output logic o_viol
);

    logic seen;
    logic last_cen;

    always_comb begin
        o_viol = 1'b0;
        if (i_active) begin
            if (i_cen && i_cenb)
                o_viol = 1'b1;
            else if (i_cen)
                o_viol = seen && last_cen;
            else if (i_cenb)
                o_viol = seen && !last_cen;
        end
    end

    // A coincident pair is flagged but leaves the tracker untouched.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_active) begin
            seen     <= 1'b0;
            last_cen <= 1'b0;
        end else if (i_cen ^ i_cenb) begin
            seen     <= 1'b1;
            last_cen <= i_cen;
        end
    end

endmodule

// File: rtl/cen_strobe_monitor.sv
// Counts i_cen strobes per WINDOW cycles, flags frequency/phase errors, reports lock.
// Latency: o_valid 2 cycles after the last window cycle; no backpressure, free-running.
module cen_strobe_monitor
    import clocks_pkg::*;
#(
    parameter logic [15:0] WINDOW    = DEF_WINDOW,
    parameter logic [15:0] EXP_COUNT = DEF_EXP_COUNT,
    parameter logic [15:0] TOL       = DEF_TOL,
    parameter logic [3:0]  LOCK_N    = DEF_LOCK_N
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_cen,
    input  logic        i_cenb,
    output logic [15:0] o_count,
    output logic        o_valid,
    output logic        o_freq_err,
    output logic        o_phase_err,
    output logic        o_locked
);

    mon_state_t  state;
    mon_state_t  state_nxt;
    logic [15:0] win_cnt;
    logic [15:0] pulse_cnt;
    logic [3:0]  good_cnt;
    logic        win_bad;
    logic        active;
    logic        eval_fire;
    logic        freq_bad;
    logic        phase_viol;

    assign active    = i_enable && (state != ST_IDLE);
    assign eval_fire = i_enable && (state == ST_EVAL);
    assign freq_bad  = abs_diff17(pulse_cnt, EXP_COUNT) > {1'b0, TOL};
    assign o_locked  = (good_cnt == LOCK_N);

    cen_phase_check u_phase (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (active),
        .i_cen    (i_cen),
        .i_cenb   (i_cenb),
        .o_viol   (phase_viol)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = ST_MEASURE;
            ST_MEASURE: if (win_cnt == WINDOW - 16'd1) state_nxt = ST_EVAL;
            ST_EVAL:    state_nxt = ST_MEASURE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (!i_enable)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !active || state == ST_EVAL) begin
            win_cnt   <= 16'd0;
            pulse_cnt <= 16'd0;
        end else begin
            win_cnt <= win_cnt + 16'd1;
            if (i_cen && pulse_cnt != 16'hFFFF)
                pulse_cnt <= pulse_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count    <= 16'd0;
            o_freq_err <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= eval_fire;
            if (eval_fire) begin
                o_count    <= pulse_cnt;
                o_freq_err <= freq_bad;
            end
        end
    end

    // A violation in the EVAL cycle still belongs to the window being closed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !active) begin
            good_cnt <= 4'd0;
            win_bad  <= 1'b0;
        end else if (state == ST_EVAL) begin
            win_bad <= 1'b0;
            if (freq_bad || win_bad || phase_viol)
                good_cnt <= 4'd0;
            else if (good_cnt != LOCK_N)
                good_cnt <= good_cnt + 4'd1;
        end else if (phase_viol) begin
            win_bad <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !active) o_phase_err <= 1'b0;
        else if (phase_viol)     o_phase_err <= 1'b1;
    end

endmodule

// File: tb/tb_cen_strobe_monitor.sv
// Three monitor instances (lock/phase/reset, 65535-cycle saturation, 4 MHz accumulator)
// compared every cycle against a frame-arithmetic model, plus literal spot checks.
module tb_cen_strobe_monitor;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a = 1'b0, en_a = 1'b0, cen_a = 1'b0, cenb_a = 1'b0;
    logic        rst_b = 1'b0, en_b = 1'b0, cen_b = 1'b0, cenb_b = 1'b0;
    logic        rst_c = 1'b0, en_c = 1'b0, cen_c = 1'b0, cenb_c = 1'b0;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic        vld_a, vld_b, vld_c, ferr_a, ferr_b, ferr_c;
    logic        perr_a, perr_b, perr_c, lock_a, lock_b, lock_c;

    cen_strobe_monitor #(.WINDOW(16'd1000), .EXP_COUNT(16'd250), .TOL(16'd1), .LOCK_N(4'd4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_enable(en_a), .i_cen(cen_a), .i_cenb(cenb_a),
        .o_count(cnt_a), .o_valid(vld_a), .o_freq_err(ferr_a), .o_phase_err(perr_a), .o_locked(lock_a));
    cen_strobe_monitor #(.WINDOW(16'd65535), .EXP_COUNT(16'd13400), .TOL(16'd1), .LOCK_N(4'd4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_enable(en_b), .i_cen(cen_b), .i_cenb(cenb_b),
        .o_count(cnt_b), .o_valid(vld_b), .o_freq_err(ferr_b), .o_phase_err(perr_b), .o_locked(lock_b));
    cen_strobe_monitor #(.WINDOW(16'd1000), .EXP_COUNT(16'd75), .TOL(16'd1), .LOCK_N(4'd4)) dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_enable(en_c), .i_cen(cen_c), .i_cenb(cenb_c),
        .o_count(cnt_c), .o_valid(vld_c), .o_freq_err(ferr_c), .o_phase_err(perr_c), .o_locked(lock_c));

    function automatic int p_w(input int d);
        return (d == 1) ? 65535 : 1000;
    endfunction
    function automatic int p_e(input int d);
        return (d == 0) ? 250 : ((d == 1) ? 13400 : 75);
    endfunction
    localparam int P_TOL  = 1;
    localparam int P_LOCK = 4;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: time since measurement start, split into frames of WINDOW+1 cycles.
    bit m_run [ND];
    int m_k [ND], m_cnt [ND], m_prev [ND], m_good [ND];
    bit m_wbad [ND];
    int e_count [ND];
    bit e_valid [ND], e_ferr [ND], e_perr [ND];
    bit chk_on [ND];

    task automatic model_step(input int d, input logic rst, input logic en, input logic c, input logic cb);
        bit viol;
        int diff;
        if (!rst) begin
            m_run[d] = 0; m_k[d] = 0; m_cnt[d] = 0; m_prev[d] = -1; m_wbad[d] = 0; m_good[d] = 0;
            e_count[d] = 0; e_valid[d] = 0; e_ferr[d] = 0; e_perr[d] = 0;
            chk_on[d] = 1;
        end else if (!en) begin
            m_run[d] = 0; m_k[d] = 0; m_cnt[d] = 0; m_prev[d] = -1; m_wbad[d] = 0; m_good[d] = 0;
            e_valid[d] = 0; e_perr[d] = 0;
        end else if (!m_run[d]) begin
            m_run[d] = 1; m_k[d] = 0; m_prev[d] = -1; e_valid[d] = 0;
        end else begin
            viol = 0;
            if (c && cb) viol = 1;
            else if (c) begin viol = (m_prev[d] == 0); m_prev[d] = 0; end
            else if (cb) begin viol = (m_prev[d] == 1); m_prev[d] = 1; end
            if (viol) begin e_perr[d] = 1; m_wbad[d] = 1; end
            if (m_k[d] % (p_w(d) + 1) < p_w(d)) begin
                if (c) m_cnt[d]++;
                e_valid[d] = 0;
            end else begin
                e_count[d] = (m_cnt[d] > 65535) ? 65535 : m_cnt[d];
                diff = (e_count[d] > p_e(d)) ? e_count[d] - p_e(d) : p_e(d) - e_count[d];
                e_ferr[d] = (diff > P_TOL);
                if (e_ferr[d] || m_wbad[d]) m_good[d] = 0;
                else if (m_good[d] < P_LOCK) m_good[d]++;
                e_valid[d] = 1;
                m_cnt[d] = 0;
                m_wbad[d] = 0;
            end
            m_k[d]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, en_a, cen_a, cenb_a);
        model_step(1, rst_b, en_b, cen_b, cenb_b);
        model_step(2, rst_c, en_c, cen_c, cenb_c);
    end

    task automatic compare(input int d, input logic [15:0] cnt, input logic v, input logic fe,
                           input logic pe, input logic lk);
        if (chk_on[d]) begin
            check($sformatf("d%0d_count", d), cnt, e_count[d]);
            check($sformatf("d%0d_valid", d), v, e_valid[d]);
            check($sformatf("d%0d_freq_err", d), fe, e_ferr[d]);
            check($sformatf("d%0d_phase_err", d), pe, e_perr[d]);
            check($sformatf("d%0d_locked", d), lk, m_good[d] == P_LOCK);
        end
    endtask

    always @(negedge clk) begin
        compare(0, cnt_a, vld_a, ferr_a, perr_a, lock_a);
        compare(1, cnt_b, vld_b, ferr_b, perr_b, lock_b);
        compare(2, cnt_c, vld_c, ferr_c, perr_c, lock_c);
    end

    function automatic logic vld_of(input int d);
        return (d == 0) ? vld_a : ((d == 1) ? vld_b : vld_c);
    endfunction

    task automatic wait_valid(input int d, input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_of(d) && n < budget);
        if (!vld_of(d)) check({tag, "_timeout"}, 0, 1);
    endtask

    // Stimulus for instance A: period-4 strobes, optional single dropped cenb, random faults.
    int mode_a = 0;
    bit drop_req_a = 0;
    bit dropped_a = 0;
    int ph_a = 0;
    bit nc_a, nb_a;
    int rr_a;
    always @(negedge clk) begin
        ph_a = (ph_a + 1) % 4;
        nc_a = (mode_a != 0) && (ph_a == 0);
        nb_a = (mode_a != 0) && (ph_a == 2);
        if (nb_a && drop_req_a && !dropped_a) begin
            nb_a = 0;
            dropped_a = 1;
        end
        if (mode_a == 2) begin
            rr_a = $urandom_range(0, 399);
            if (rr_a == 0) nc_a = !nc_a;
            else if (rr_a == 1) nb_a = !nb_a;
            else if (rr_a == 2) begin nc_a = 1; nb_a = 1; end
        end
        cen_a  = nc_a;
        cenb_a = nb_a;
    end

    // Instance C: 16-bit phase accumulator, cenb half a period after cen.
    logic [15:0] acc_c = 16'd0;
    logic [16:0] sum_c;
    always @(negedge clk) begin
        sum_c  = {1'b0, acc_c} + 17'd4891;
        cen_c  = sum_c[16];
        cenb_c = !acc_c[15] && sum_c[15];
        acc_c  = sum_c[15:0];
    end

    bit done_a = 0, done_b = 0, done_c = 0;

    initial begin : ctrl_a
        int k;
        rst_a = 1'b0; en_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_count", cnt_a, 0);
        check("a_reset_valid", vld_a, 0);
        check("a_reset_freq_err", ferr_a, 0);
        check("a_reset_phase_err", perr_a, 0);
        check("a_reset_locked", lock_a, 0);
        rst_a = 1'b1;
        @(negedge clk);
        en_a = 1'b1; mode_a = 1;
        for (int w = 1; w <= 4; w++) begin
            wait_valid(0, 1100, "a_lock_win");
            check("a_win_count", cnt_a, 250);
            check("a_win_freq_err", ferr_a, 0);
            check("a_win_locked", lock_a, w == 4);
        end
        check("model_a_count_pin", e_count[0], 250);
        drop_req_a = 1;
        check("a_phase_before_drop", perr_a, 0);
        wait_valid(0, 1100, "a_drop_win");
        check("a_drop_phase_err", perr_a, 1);
        check("a_drop_locked", lock_a, 0);
        check("a_drop_count", cnt_a, 250);
        wait_valid(0, 1100, "a_after_drop_win");
        check("a_sticky_phase_err", perr_a, 1);
        check("a_after_drop_locked", lock_a, 0);
        // o_valid marks window cycle 0; assert reset during window cycle 500.
        repeat (500) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("a_midrst_count", cnt_a, 0);
        check("a_midrst_valid", vld_a, 0);
        check("a_midrst_freq_err", ferr_a, 0);
        check("a_midrst_phase_err", perr_a, 0);
        check("a_midrst_locked", lock_a, 0);
        rst_a = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vld_a && k < 1200);
        check("a_first_valid_latency", k, 1002);
        mode_a = 2;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(200, 2500)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                rst_a = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_a = 1'b1;
            end else begin
                en_a = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                en_a = 1'b1;
            end
        end
        repeat (2200) @(negedge clk);
        done_a = 1;
    end

    initial begin : ctrl_b
        rst_b = 1'b0; en_b = 1'b0; cen_b = 1'b0; cenb_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        en_b = 1'b1; cen_b = 1'b1; cenb_b = 1'b1;
        wait_valid(1, 66000, "b_sat_win");
        check("b_sat_count", cnt_b, 16'hFFFF);
        check("b_sat_freq_err", ferr_b, 1);
        check("b_sat_phase_err", perr_b, 1);
        check("b_sat_locked", lock_b, 0);
        check("model_b_count_pin", e_count[1], 65535);
        repeat (3) @(negedge clk);
        done_b = 1;
    end

    initial begin : ctrl_c
        rst_c = 1'b0; en_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_c = 1'b1;
        en_c = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            wait_valid(2, 1100, "c_acc_win");
            check("c_count_in_74_75", (cnt_c == 16'd74 || cnt_c == 16'd75), 1);
            check("c_freq_err", ferr_c, 0);
            check("c_phase_err", perr_c, 0);
        end
        check("c_locked", lock_c, 1);
        done_c = 1;
    end

    initial begin : main
        int n;
        n = 0;
        while (!(done_a && done_b && done_c) && n < 90000) begin
            @(negedge clk);
            n++;
        end
        if (!(done_a && done_b && done_c)) check("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
